// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer. It accepts an N/M/C0 request, then drives the
// Avalon-MM reconfig controller through mode/N/M/C0/start writes. After that it
// polls the status register and waits for a stable PLL lock. A timeout sets a
// sticky error flag.
module pll_reconfig_seq #(
  parameter int unsigned TIMEOUT_CYCLES  = 65535,
  parameter int unsigned MIN_LOCK_CYCLES = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c0,
  output logic [5:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        pll_locked,
  output logic        done,
  output logic        error,
  output logic        busy
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LockW  = $clog2(MIN_LOCK_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [LockW-1:0]  LockLast  = LockW'(MIN_LOCK_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StWrMode, StWrN, StWrM, StWrC0, StWrStart, StPoll, StLockWait, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [LockW-1:0]  lock_cnt_q, lock_cnt_d;
  logic              gap_q, gap_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [17:0]       n_q, n_d, m_q, m_d, c0_q, c0_d;
  logic              lock_meta_q, lock_sync_q;
  logic              rd_req;
  logic              lock_hit;

  // Only the done bit of the status word matters.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:1];

  assign cfg_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign error     = error_q;

  // State, counters, captured config and the lock synchronizer.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      lock_cnt_q  <= '0;
      gap_q       <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      n_q         <= '0;
      m_q         <= '0;
      c0_q        <= '0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lock_cnt_q  <= lock_cnt_d;
      gap_q       <= gap_d;
      done_q      <= done_d;
      error_q     <= error_d;
      n_q         <= n_d;
      m_q         <= m_d;
      c0_q        <= c0_d;
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  // Next-state logic and Avalon-MM outputs decoded from the current state.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    lock_cnt_d    = lock_cnt_q;
    gap_d         = gap_q;
    done_d        = 1'b0;
    error_d       = error_q;
    n_d           = n_q;
    m_d           = m_q;
    c0_d          = c0_q;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = 6'd0;
    avm_writedata = 32'd0;
    rd_req        = 1'b0;
    lock_hit      = lock_sync_q && (lock_cnt_q == LockLast);

    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          n_d     = cfg_n;
          m_d     = cfg_m;
          c0_d    = cfg_c0;
          error_d = 1'b0;
          state_d = StWrMode;
        end
      end
      StWrMode: begin
        avm_write     = 1'b1;
        avm_address   = 6'd0;
        avm_writedata = 32'd1;
        if (!avm_waitrequest) state_d = StWrN;
      end
      StWrN: begin
        avm_write     = 1'b1;
        avm_address   = 6'd3;
        avm_writedata = {14'd0, n_q};
        if (!avm_waitrequest) state_d = StWrM;
      end
      StWrM: begin
        avm_write     = 1'b1;
        avm_address   = 6'd4;
        avm_writedata = {14'd0, m_q};
        if (!avm_waitrequest) state_d = StWrC0;
      end
      StWrC0: begin
        // Upper bits carry the counter select, which is C0 (zero).
        avm_write     = 1'b1;
        avm_address   = 6'd5;
        avm_writedata = {9'd0, 5'd0, c0_q};
        if (!avm_waitrequest) state_d = StWrStart;
      end
      StWrStart: begin
        avm_write     = 1'b1;
        avm_address   = 6'd2;
        avm_writedata = 32'd1;
        if (!avm_waitrequest) begin
          state_d = StPoll;
          timer_d = '0;
          gap_d   = 1'b0;
        end
      end
      StPoll: begin
        // Alternate read / idle gap until the status done bit comes back set.
        rd_req      = !gap_q;
        avm_read    = rd_req;
        avm_address = 6'd1;
        if (rd_req && !avm_waitrequest && avm_readdata[0]) begin
          state_d    = StLockWait;
          timer_d    = '0;
          lock_cnt_d = '0;
        end else if (timer_q == TimerLast) begin
          state_d = StErr;
          error_d = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
          if (gap_q) begin
            gap_d = 1'b0;
          end else if (!avm_waitrequest) begin
            gap_d = 1'b1;
          end
        end
      end
      StLockWait: begin
        if (lock_hit) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (timer_q == TimerLast) begin
          state_d = StErr;
          error_d = 1'b1;
        end else begin
          timer_d    = timer_q + TimerW'(1);
          lock_cnt_d = lock_sync_q ? lock_cnt_q + LockW'(1) : '0;
        end
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: happy path, write stall, poll timeout,
// lock glitch, mid-write reset and requests while busy.
module tb_pll_reconfig_seq;

  logic        clk_clk;
  logic        reset_reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [17:0] cfg_n, cfg_m, cfg_c0;
  logic [5:0]  avm_address;
  logic        avm_write, avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        pll_locked;
  logic        done, error, busy;

  int checks = 0;
  int failures = 0;

  // Responder / monitor state.
  int status_on_read = 0;
  int reads_done = 0;
  int stall_left = 0;
  int hold_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  logic force_wait = 1'b0;
  logic [63:0] wr_q[$];

  pll_reconfig_seq #(
    .TIMEOUT_CYCLES (100),
    .MIN_LOCK_CYCLES(16)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_n          (cfg_n),
    .cfg_m          (cfg_m),
    .cfg_c0         (cfg_c0),
    .avm_address    (avm_address),
    .avm_write      (avm_write),
    .avm_read       (avm_read),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .pll_locked     (pll_locked),
    .done           (done),
    .error          (error),
    .busy           (busy)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive slave responses, record what completes, advance.
  task automatic cyc();
    if (status_on_read != 0 && reads_done + 1 >= status_on_read) avm_readdata = 32'h0000_0001;
    else avm_readdata = 32'hFFFF_FFFE;
    avm_waitrequest = force_wait;
    if (avm_write && avm_address == 6'd4 && stall_left > 0) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end
    if (avm_write && avm_address == 6'd4 && avm_writedata == 32'h808) hold_cnt++;
    if (avm_write && !avm_waitrequest) wr_q.push_back({26'd0, avm_address, avm_writedata});
    if (avm_read && !avm_waitrequest) reads_done++;
    if (avm_write && avm_read) overlap_cnt++;
    if (done) done_cnt++;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic clear_stats();
    reads_done = 0;
    hold_cnt   = 0;
    done_cnt   = 0;
    wr_q.delete();
  endtask

  task automatic request(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c0);
    cfg_valid = 1'b1;
    cfg_n     = n;
    cfg_m     = m;
    cfg_c0    = c0;
    cyc();
    cfg_valid = 1'b0;
  endtask

  // Run until done (or error), counting cycles from the first busy cycle.
  task automatic run(input bit stop_on_err, input int glitch_k, input int valid_k,
                     output int k);
    k = 0;
    while (!(stop_on_err ? error : done) && k < 400) begin
      if (k == glitch_k) pll_locked = 1'b0;
      if (k == glitch_k + 1) pll_locked = 1'b1;
      if (k == valid_k) begin
        cfg_valid = 1'b1;
        cfg_n     = 18'h3FFFF;
        cfg_m     = 18'h15555;
        cfg_c0    = 18'h2AAAA;
      end else begin
        cfg_valid = 1'b0;
      end
      cyc();
      k++;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input logic [17:0] n, input logic [17:0] m,
                              input logic [17:0] c0);
    logic [63:0] exp [5];
    exp[0] = {26'd0, 6'd0, 32'd1};
    exp[1] = {26'd0, 6'd3, 14'd0, n};
    exp[2] = {26'd0, 6'd4, 14'd0, m};
    exp[3] = {26'd0, 6'd5, 14'd0, c0};
    exp[4] = {26'd0, 6'd2, 32'd1};
    chk({tag, "_nwrites"}, 64'(wr_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_q.size()) chk($sformatf("%s_wr%0d", tag, i), wr_q[i], exp[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_write"}, 64'(avm_write), 64'd0);
    chk({tag, "_read"}, 64'(avm_read), 64'd0);
    chk({tag, "_addr"}, 64'(avm_address), 64'd0);
    chk({tag, "_wdata"}, 64'(avm_writedata), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'(cfg_ready), 64'd1);
  endtask

  initial begin
    int k;
    reset_reset     = 1'b1;
    cfg_valid       = 1'b0;
    cfg_n           = '0;
    cfg_m           = '0;
    cfg_c0          = '0;
    avm_readdata    = '0;
    avm_waitrequest = 1'b0;
    pll_locked      = 1'b1;
    @(posedge clk_clk);
    #1;

    // Reset state.
    cyc();
    cyc();
    check_reset_outputs("rst");
    reset_reset = 1'b0;
    cyc();
    chk("rst_idle_ready", 64'(cfg_ready), 64'd1);

    // Happy path: status set on the 3rd poll, lock steady.
    clear_stats();
    status_on_read = 3;
    request(18'h00101, 18'h00808, 18'h00202);
    chk("happy_busy", 64'(busy), 64'd1);
    chk("happy_ready_low", 64'(cfg_ready), 64'd0);
    run(1'b0, -10, -10, k);
    chk("happy_latency", 64'(k), 64'd26);
    chk("happy_polls", 64'(reads_done), 64'd3);
    chk("happy_idle_at_done", 64'(cfg_ready), 64'd1);
    cyc();
    chk("happy_done_pulse", 64'(done), 64'd0);
    chk("happy_done_cnt", 64'(done_cnt), 64'd1);
    chk("happy_error", 64'(error), 64'd0);
    check_writes("happy", 18'h00101, 18'h00808, 18'h00202);

    // waitrequest stalls the M write for 5 cycles.
    clear_stats();
    stall_left = 5;
    request(18'h00101, 18'h00808, 18'h00202);
    run(1'b0, -10, -10, k);
    cyc();
    chk("stall_hold", 64'(hold_cnt), 64'd6);
    chk("stall_latency", 64'(k), 64'd31);
    chk("stall_done_cnt", 64'(done_cnt), 64'd1);
    check_writes("stall", 18'h00101, 18'h00808, 18'h00202);

    // Status never sets: timeout after 100 poll cycles.
    clear_stats();
    status_on_read = 0;
    request(18'h00011, 18'h00022, 18'h00033);
    run(1'b1, -10, -10, k);
    chk("to_latency", 64'(k), 64'd105);
    chk("to_err_busy", 64'(busy), 64'd1);
    chk("to_err_read", 64'(avm_read), 64'd0);
    chk("to_reads", 64'(reads_done), 64'd50);
    cyc();
    chk("to_back_idle", 64'(cfg_ready), 64'd1);
    chk("to_error_sticky", 64'(error), 64'd1);
    chk("to_no_done", 64'(done_cnt), 64'd0);
    clear_stats();
    status_on_read = 1;
    request(18'h00011, 18'h00022, 18'h00033);
    chk("to_error_cleared", 64'(error), 64'd0);
    run(1'b0, -10, -10, k);
    cyc();
    chk("to_recover_latency", 64'(k), 64'd22);
    check_writes("to_recover", 18'h00011, 18'h00022, 18'h00033);

    // Lock glitches low once after 10 locked cycles.
    clear_stats();
    request(18'h00101, 18'h00808, 18'h00202);
    run(1'b0, 14, -10, k);
    cyc();
    chk("glitch_latency", 64'(k), 64'd33);
    chk("glitch_done_cnt", 64'(done_cnt), 64'd1);

    // Reset during a stalled N write.
    clear_stats();
    request(18'h00101, 18'h00808, 18'h00202);
    cyc();
    force_wait = 1'b1;
    cyc();
    cyc();
    chk("rstmid_in_wrn", 64'(avm_address), 64'd3);
    reset_reset = 1'b1;
    cyc();
    check_reset_outputs("rstmid");
    reset_reset = 1'b0;
    force_wait  = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("rstmid_no_done", 64'(done_cnt), 64'd0);
    chk("rstmid_writes", 64'(wr_q.size()), 64'd1);
    clear_stats();
    request(18'h00044, 18'h00055, 18'h00066);
    chk("restart_addr", 64'(avm_address), 64'd0);
    chk("restart_data", 64'(avm_writedata), 64'd1);
    chk("restart_write", 64'(avm_write), 64'd1);
    run(1'b0, -10, -10, k);
    cyc();
    chk("restart_latency", 64'(k), 64'd22);
    check_writes("restart", 18'h00044, 18'h00055, 18'h00066);

    // cfg_valid while busy must not re-capture or restart.
    clear_stats();
    request(18'h00101, 18'h00808, 18'h00202);
    run(1'b0, -10, 0, k);
    cyc();
    chk("busyreq_latency", 64'(k), 64'd22);
    chk("busyreq_done_cnt", 64'(done_cnt), 64'd1);
    check_writes("busyreq", 18'h00101, 18'h00808, 18'h00202);
    chk("busyreq_idle", 64'(busy), 64'd0);

    chk("no_rw_overlap", 64'(overlap_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
